// File: rtl/analyzer_pkg.sv
// Shared types and constants for the logic-analyzer capture engine:
// FSM state encoding, default parameter values and the RAM depth helper.
package analyzer_pkg;

  localparam int DEF_WAVE_ADDR_WIDTH = 12;
  localparam int DEF_DIGITAL_IN_NUM  = 8;
  localparam int DEF_DIV_WIDTH       = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Number of samples held by a capture RAM with the given address width.
  function automatic int unsigned save_cnt(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/analyzer_capture_core_if.sv
// Bundle of configuration, pin, status and read-out signals of the capture
// engine. The pattern-trigger signals exist only when
// ANALYZER_PATTERN_TRIG_EN is defined.
interface analyzer_capture_core_if import analyzer_pkg::*; #(
  parameter int WAVE_ADDR_WIDTH = DEF_WAVE_ADDR_WIDTH,
  parameter int DIGITAL_IN_NUM  = DEF_DIGITAL_IN_NUM,
  parameter int DIV_WIDTH       = DEF_DIV_WIDTH
);

  logic [DIGITAL_IN_NUM-1:0]  digital_in;
  logic                       arm;
  logic                       stop;
  logic                       trig;
  logic [DIV_WIDTH-1:0]       sample_div;
  logic [WAVE_ADDR_WIDTH-1:0] pre_depth;
  logic                       busy;
  logic                       triggered;
  logic                       done;
  logic [WAVE_ADDR_WIDTH-1:0] wave_addr;
  logic [DIGITAL_IN_NUM-1:0]  wave_out;

`ifdef ANALYZER_PATTERN_TRIG_EN
  logic [DIGITAL_IN_NUM-1:0]  trig_mask;
  logic [DIGITAL_IN_NUM-1:0]  trig_value;

  modport master (
    output digital_in, arm, stop, trig, sample_div, pre_depth, wave_addr,
           trig_mask, trig_value,
    input  busy, triggered, done, wave_out
  );

  modport slave (
    input  digital_in, arm, stop, trig, sample_div, pre_depth, wave_addr,
           trig_mask, trig_value,
    output busy, triggered, done, wave_out
  );
`else
  modport master (
    output digital_in, arm, stop, trig, sample_div, pre_depth, wave_addr,
    input  busy, triggered, done, wave_out
  );

  modport slave (
    input  digital_in, arm, stop, trig, sample_div, pre_depth, wave_addr,
    output busy, triggered, done, wave_out
  );
`endif

endinterface

// File: rtl/analyzer_wave_ram.sv
// Simple dual-port sample RAM: one write port, one read port with a
// registered output. The output register clears on reset; contents do not.
module analyzer_wave_ram import analyzer_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_WAVE_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DIGITAL_IN_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = save_cnt(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port: store one sample per enabled cycle.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: registered read, one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/analyzer_capture_core.sv
// Logic-analyzer capture engine: divided-rate sampling into a circular RAM
// with a programmable pre-trigger window and chronological read-out.
// Optional build macro ANALYZER_PATTERN_TRIG_EN adds a masked-pattern
// trigger alongside the external trig input.
module analyzer_capture_core import analyzer_pkg::*; #(
  parameter int WAVE_ADDR_WIDTH = DEF_WAVE_ADDR_WIDTH,
  parameter int DIGITAL_IN_NUM  = DEF_DIGITAL_IN_NUM,
  parameter int DIV_WIDTH       = DEF_DIV_WIDTH
) (
  input logic                    clk,
  input logic                    rst,
  analyzer_capture_core_if.slave bus
);

  localparam int unsigned SAVE_CNT = save_cnt(WAVE_ADDR_WIDTH);
  // Counter is one bit wider than the address so it can hold SAVE_CNT.
  localparam int          CW       = WAVE_ADDR_WIDTH + 1;

  state_t                     state_q,      state_d;
  logic [WAVE_ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DIV_WIDTH-1:0]       div_cnt_q,    div_cnt_d;
  logic [DIV_WIDTH-1:0]       div_l_q,      div_l_d;
  logic [WAVE_ADDR_WIDTH-1:0] pre_l_q,      pre_l_d;
  logic [CW-1:0]              cnt_q,        cnt_d;
  logic [WAVE_ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
  logic                       trig_pend_q,  trig_pend_d;

  logic                       capturing;
  logic                       sample_tick;
  logic                       pat_hit;
  logic                       trig_fire;
  logic                       arm_ok;
  logic                       ram_we;
  logic [CW-1:0]              post_total;
  logic [WAVE_ADDR_WIDTH-1:0] ram_raddr;

`ifdef ANALYZER_PATTERN_TRIG_EN
  logic [DIGITAL_IN_NUM-1:0]  mask_l_q,  mask_l_d;
  logic [DIGITAL_IN_NUM-1:0]  value_l_q, value_l_d;

  // A zero mask would match every sample, so it disables the pattern trigger.
  assign pat_hit = (state_q == ST_WAIT_TRIG) && (|mask_l_q) &&
                   ((bus.digital_in & mask_l_q) == (value_l_q & mask_l_q));
`else
  assign pat_hit = 1'b0;
`endif

  assign capturing   = state_q inside {ST_PRE, ST_WAIT_TRIG, ST_POST};
  assign sample_tick = (div_cnt_q == div_l_q);
  assign trig_fire   = bus.trig | trig_pend_q | pat_hit;
  assign arm_ok      = bus.arm && !bus.stop;
  assign ram_we      = capturing && sample_tick;
  // Samples still to be stored from the trigger sample onwards.
  assign post_total  = CW'(SAVE_CNT) - {1'b0, pre_l_q};
  // Chronological index 0 maps to the oldest sample of the capture.
  assign ram_raddr   = start_addr_q + bus.wave_addr;

  // Next-state and datapath update for the capture FSM.
  always_comb begin
    state_d      = state_q;
    write_addr_d = write_addr_q;
    div_cnt_d    = div_cnt_q;
    div_l_d      = div_l_q;
    pre_l_d      = pre_l_q;
    cnt_d        = cnt_q;
    start_addr_d = start_addr_q;
    trig_pend_d  = trig_pend_q;
`ifdef ANALYZER_PATTERN_TRIG_EN
    mask_l_d     = mask_l_q;
    value_l_d    = value_l_q;
`endif

    if (capturing) begin
      div_cnt_d = sample_tick ? '0 : div_cnt_q + 1'b1;
    end
    if (ram_we) begin
      write_addr_d = write_addr_q + 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_ok) begin
          div_l_d      = bus.sample_div;
          pre_l_d      = bus.pre_depth;
`ifdef ANALYZER_PATTERN_TRIG_EN
          mask_l_d     = bus.trig_mask;
          value_l_d    = bus.trig_value;
`endif
          div_cnt_d    = '0;
          cnt_d        = '0;
          write_addr_d = '0;
          trig_pend_d  = 1'b0;
          state_d      = (bus.pre_depth == '0) ? ST_WAIT_TRIG : ST_PRE;
        end
      end
      ST_PRE: begin
        // Triggers are deliberately ignored until the pre-window is full.
        if (sample_tick) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == {1'b0, pre_l_q}) begin
            state_d = ST_WAIT_TRIG;
          end
        end
      end
      ST_WAIT_TRIG: begin
        if (sample_tick) begin
          if (trig_fire) begin
            start_addr_d = write_addr_q - pre_l_q;
            cnt_d        = CW'(1);
            trig_pend_d  = 1'b0;
            state_d      = (post_total == CW'(1)) ? ST_DONE : ST_POST;
          end
        end else if (bus.trig) begin
          // Remember a trigger pulse that falls between sample ticks.
          trig_pend_d = 1'b1;
        end
      end
      ST_POST: begin
        if (sample_tick) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == post_total) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (bus.stop) begin
      state_d     = ST_IDLE;
      trig_pend_d = 1'b0;
    end
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      write_addr_q <= '0;
      div_cnt_q    <= '0;
      div_l_q      <= '0;
      pre_l_q      <= '0;
      cnt_q        <= '0;
      start_addr_q <= '0;
      trig_pend_q  <= 1'b0;
`ifdef ANALYZER_PATTERN_TRIG_EN
      mask_l_q     <= '0;
      value_l_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      write_addr_q <= write_addr_d;
      div_cnt_q    <= div_cnt_d;
      div_l_q      <= div_l_d;
      pre_l_q      <= pre_l_d;
      cnt_q        <= cnt_d;
      start_addr_q <= start_addr_d;
      trig_pend_q  <= trig_pend_d;
`ifdef ANALYZER_PATTERN_TRIG_EN
      mask_l_q     <= mask_l_d;
      value_l_q    <= value_l_d;
`endif
    end
  end

  assign bus.busy      = capturing;
  assign bus.triggered = (state_q == ST_POST);
  assign bus.done      = (state_q == ST_DONE);

  analyzer_wave_ram #(
    .ADDR_WIDTH (WAVE_ADDR_WIDTH),
    .DATA_WIDTH (DIGITAL_IN_NUM)
  ) u_wave_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we),
    .waddr_i (write_addr_q),
    .wdata_i (bus.digital_in),
    .raddr_i (ram_raddr),
    .rdata_o (bus.wave_out)
  );

endmodule

// File: tb/tb_analyzer_capture_core.sv
// Self-checking bench for analyzer_capture_core. Sample values written at
// each expected tick are recorded as the pins are driven; read-out
// expectations are pushed to a queue and popped when wave_out is valid.
module tb_analyzer_capture_core;
  import analyzer_pkg::*;

  localparam int AW   = 12;
  localparam int NCH  = 8;
  localparam int DIVW = 16;
  localparam int SAVE = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  analyzer_capture_core_if #(.WAVE_ADDR_WIDTH(AW), .DIGITAL_IN_NUM(NCH), .DIV_WIDTH(DIVW)) bus ();

  analyzer_capture_core #(.WAVE_ADDR_WIDTH(AW), .DIGITAL_IN_NUM(NCH), .DIV_WIDTH(DIVW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         obs_trig, obs_done;
  bit         obs_busy_gap;
  logic [7:0] probe_din;
  logic [7:0] hist[$];
  logic [7:0] exp_q[$];
  int         m_ph = 0;
  int         m_div = 0;
  bit         m_run = 0;
  bit         din_ramp = 0;

  // One clock: record the sample written if this edge is a tick, then advance.
  task automatic step();
    if (m_run) begin
      m_ph++;
      if (m_ph == m_div + 1) begin
        m_ph = 0;
        hist.push_back(bus.digital_in);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (din_ramp) bus.digital_in = cyc[7:0];
  endtask

  task automatic do_arm(input int div, input int pre);
    bus.sample_div = div[DIVW-1:0];
    bus.pre_depth  = pre[AW-1:0];
    bus.arm = 1'b1;
    m_run = 0;
    step();
    bus.arm = 1'b0;
    hist.delete();
    m_run = 1;
    m_ph  = 0;
    m_div = div;
  endtask

  // Drive trig at iterations ta/tb2, note first triggered/done iterations.
  task automatic run_capture(input int ta, input int tb2, input int probe, input int max_c);
    obs_trig = -1;
    obs_done = -1;
    obs_busy_gap = 0;
    for (int c = 0; c < max_c; c++) begin
      bus.trig = (c == ta) || (c == tb2);
      if (c == probe) probe_din = bus.digital_in;
      step();
      if (bus.triggered === 1'b1 && obs_trig < 0) obs_trig = c;
      if (bus.done === 1'b1) begin
        obs_done = c;
        m_run = 0;
        break;
      end
      if (bus.busy !== 1'b1) obs_busy_gap = 1;
    end
    bus.trig = 1'b0;
  endtask

  task automatic issue_read(input int a, input logic [7:0] e);
    bus.wave_addr = a[AW-1:0];
    exp_q.push_back(e);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.triggered !== 1'b0) begin failures++; $display("FAIL reset_triggered: got %b expected 0", bus.triggered); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.wave_out !== 8'h00) begin failures++; $display("FAIL reset_wave_out: got %02h expected 00", bus.wave_out); end
    rst = 1'b0;
    step();
    $display("test_reset: done");
  endtask

  task automatic test_pre_post();
    int addrs[6] = '{0, 1, 101, 2000, 3695, 4095};
    logic [7:0] got, e;
    din_ramp = 1;
    do_arm(0, 100);
    run_capture(500, -1, 500, 6000);
    checks++; if (obs_trig !== 500) begin failures++; $display("FAIL pre_post_trig_cycle: got %0d expected 500", obs_trig); end
    checks++; if (obs_done !== 500 + SAVE - 100 - 1) begin failures++; $display("FAIL pre_post_done_cycle: got %0d expected %0d", obs_done, 500 + SAVE - 101); end
    checks++; if (obs_busy_gap !== 1'b0) begin failures++; $display("FAIL pre_post_busy_gap: got %b expected 0", obs_busy_gap); end
    e = probe_din;
    issue_read(100, e);
    got = bus.wave_out; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL pre_post_trig_sample: got %02h expected %02h", got, e); end
    e = probe_din - 8'd1;
    issue_read(99, e);
    got = bus.wave_out; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL pre_post_trig_minus1: got %02h expected %02h", got, e); end
    foreach (addrs[i]) begin
      issue_read(addrs[i], hist[400 + addrs[i]]);
      got = bus.wave_out; e = exp_q.pop_front();
      checks++; if (got !== e) begin failures++; $display("FAIL pre_post_read[%0d]: got %02h expected %02h", addrs[i], got, e); end
    end
    $display("test_pre_post: trig at %0d, done at %0d", obs_trig, obs_done);
  endtask

  task automatic test_zero_pre();
    int addrs[3] = '{1, 2048, 4095};
    logic [7:0] got, e;
    din_ramp = 1;
    do_arm(0, 0);
    run_capture(3, -1, 3, 6000);
    checks++; if (obs_trig !== 3) begin failures++; $display("FAIL zero_pre_trig_cycle: got %0d expected 3", obs_trig); end
    checks++; if (obs_done !== 3 + SAVE - 1) begin failures++; $display("FAIL zero_pre_done_cycle: got %0d expected %0d", obs_done, 3 + SAVE - 1); end
    issue_read(0, probe_din);
    got = bus.wave_out; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL zero_pre_trig_sample: got %02h expected %02h", got, e); end
    foreach (addrs[i]) begin
      issue_read(addrs[i], hist[3 + addrs[i]]);
      got = bus.wave_out; e = exp_q.pop_front();
      checks++; if (got !== e) begin failures++; $display("FAIL zero_pre_read[%0d]: got %02h expected %02h", addrs[i], got, e); end
    end
    $display("test_zero_pre: trig at %0d, done at %0d", obs_trig, obs_done);
  endtask

  task automatic test_div_pending();
    int addrs[3] = '{0, 9, 4095};
    logic [7:0] got, e;
    din_ramp = 1;
    do_arm(3, 8);
    // Ticks land on iterations 3,7,11,...; trig at 41 falls between ticks.
    run_capture(41, -1, 43, 20000);
    checks++; if (obs_trig !== 43) begin failures++; $display("FAIL div_pend_trig_cycle: got %0d expected 43", obs_trig); end
    checks++; if (obs_done !== 16391) begin failures++; $display("FAIL div_pend_done_cycle: got %0d expected 16391", obs_done); end
    issue_read(8, probe_din);
    got = bus.wave_out; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL div_pend_trig_sample: got %02h expected %02h", got, e); end
    e = probe_din - 8'd4;
    issue_read(7, e);
    got = bus.wave_out; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL div_pend_spacing: got %02h expected %02h", got, e); end
    foreach (addrs[i]) begin
      issue_read(addrs[i], hist[2 + addrs[i]]);
      got = bus.wave_out; e = exp_q.pop_front();
      checks++; if (got !== e) begin failures++; $display("FAIL div_pend_read[%0d]: got %02h expected %02h", addrs[i], got, e); end
    end
    $display("test_div_pending: trig at %0d, done at %0d", obs_trig, obs_done);
  endtask

  task automatic test_early_trig();
    int addrs[5] = '{0, 999, 3595, 3596, 4095};
    logic [7:0] got, e;
    din_ramp = 1;
    do_arm(0, 1000);
    run_capture(10, 1500, 1500, 8000);
    checks++; if (obs_trig !== 1500) begin failures++; $display("FAIL early_trig_cycle: got %0d expected 1500", obs_trig); end
    checks++; if (obs_busy_gap !== 1'b0) begin failures++; $display("FAIL early_trig_busy_gap: got %b expected 0", obs_busy_gap); end
    checks++; if (obs_done !== 1500 + SAVE - 1000 - 1) begin failures++; $display("FAIL early_trig_done_cycle: got %0d expected %0d", obs_done, 1500 + SAVE - 1001); end
    issue_read(1000, probe_din);
    got = bus.wave_out; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL early_trig_sample: got %02h expected %02h", got, e); end
    foreach (addrs[i]) begin
      issue_read(addrs[i], hist[500 + addrs[i]]);
      got = bus.wave_out; e = exp_q.pop_front();
      checks++; if (got !== e) begin failures++; $display("FAIL early_trig_read[%0d]: got %02h expected %02h", addrs[i], got, e); end
    end
    $display("test_early_trig: trig at %0d, done at %0d", obs_trig, obs_done);
  endtask

  task automatic test_abort_reset();
    logic [7:0] got, e;
    din_ramp = 1;
    do_arm(0, 4);
    run_capture(10, -1, -1, 20);
    checks++; if (bus.triggered !== 1'b1) begin failures++; $display("FAIL abort_in_post: got %b expected 1", bus.triggered); end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    m_run = 0;
    checks++; if ({bus.busy, bus.triggered, bus.done} !== 3'b000) begin failures++; $display("FAIL abort_stop_status: got %b expected 000", {bus.busy, bus.triggered, bus.done}); end
    do_arm(0, 4);
    run_capture(10, -1, -1, 20);
    checks++; if (bus.triggered !== 1'b1) begin failures++; $display("FAIL abort_rearm_post: got %b expected 1", bus.triggered); end
    rst = 1'b1;
    step();
    m_run = 0;
    checks++; if ({bus.busy, bus.triggered, bus.done, bus.wave_out} !== 11'd0) begin failures++; $display("FAIL abort_rst_status: got %b expected 0", {bus.busy, bus.triggered, bus.done, bus.wave_out}); end
    rst = 1'b0;
    step();
    // A second arm while busy must not disturb the latched div=0 / pre=50.
    do_arm(0, 50);
    bus.sample_div = 16'd3;
    bus.pre_depth  = 12'd7;
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    run_capture(59, -1, 59, 6000);
    checks++; if (obs_trig !== 59) begin failures++; $display("FAIL busy_arm_trig_cycle: got %0d expected 59", obs_trig); end
    checks++; if (obs_done !== 4104) begin failures++; $display("FAIL busy_arm_done_cycle: got %0d expected 4104", obs_done); end
    issue_read(50, probe_din);
    got = bus.wave_out; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL busy_arm_trig_sample: got %02h expected %02h", got, e); end
    $display("test_abort_reset: busy-arm trig at %0d, done at %0d", obs_trig, obs_done);
  endtask

`ifdef ANALYZER_PATTERN_TRIG_EN
  task automatic test_pattern();
    logic [7:0] got, e;
    din_ramp = 0;
    bus.digital_in = 8'h30;
    bus.trig_mask  = 8'h0F;
    bus.trig_value = 8'h05;
    do_arm(0, 4);
    bus.trig_mask  = 8'h00;
    obs_trig = -1;
    obs_done = -1;
    for (int c = 0; c < 6000; c++) begin
      bus.digital_in = (c == 20) ? 8'h35 : 8'h30;
      step();
      if (bus.triggered === 1'b1 && obs_trig < 0) obs_trig = c;
      if (bus.done === 1'b1) begin obs_done = c; m_run = 0; break; end
    end
    checks++; if (obs_trig !== 20) begin failures++; $display("FAIL pattern_trig_cycle: got %0d expected 20", obs_trig); end
    checks++; if (obs_done !== 20 + SAVE - 4 - 1) begin failures++; $display("FAIL pattern_done_cycle: got %0d expected %0d", obs_done, 20 + SAVE - 5); end
    issue_read(4, 8'h35);
    got = bus.wave_out; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL pattern_trig_sample: got %02h expected %02h", got, e); end
    issue_read(3, 8'h30);
    got = bus.wave_out; e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++; $display("FAIL pattern_pre_sample: got %02h expected %02h", got, e); end
    bus.digital_in = 8'h35;
    bus.trig_mask  = 8'h00;
    do_arm(0, 0);
    run_capture(-1, -1, -1, 200);
    checks++; if (obs_trig !== -1) begin failures++; $display("FAIL pattern_mask0: got %0d expected -1", obs_trig); end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    m_run = 0;
    $display("test_pattern: trig at %0d, done at %0d", obs_trig, obs_done);
  endtask
`endif

  initial begin
    bus.digital_in = '0;
    bus.arm        = 1'b0;
    bus.stop       = 1'b0;
    bus.trig       = 1'b0;
    bus.sample_div = '0;
    bus.pre_depth  = '0;
    bus.wave_addr  = '0;
`ifdef ANALYZER_PATTERN_TRIG_EN
    bus.trig_mask  = '0;
    bus.trig_value = '0;
`endif
    test_reset();
    test_pre_post();
    test_zero_pre();
    test_div_pending();
    test_early_trig();
    test_abort_reset();
`ifdef ANALYZER_PATTERN_TRIG_EN
    test_pattern();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
